// File: rtl/neuron_operand_loader.sv
// -----------------------------------------------------------------------------
// neuron_operand_loader
//
// Purpose:
//   Upstream feeder for the serial MAC neuron. Collects one {x, w, mask}
//   element per beat from a valid/ready stream and packs each frame into flat
//   vectors (element 0 in the LSBs). The packed frame, together with the bias
//   and activation select captured on beat 0, is offered on a valid/ready port
//   that connects to the neuron's in_valid/in_ready.
//
//   Frame-length errors are corrected so the neuron always sees exactly
//   NUM_INPUTS elements:
//     - a frame that ends early is zero-padded (err_short pulses),
//     - a frame that overruns has its excess beats dropped (err_long pulses).
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous reset, active-high
//   s_valid      element beat valid
//   s_ready      loader can accept a beat (low only while offering a frame)
//   s_x          element sample x[k] (signed)
//   s_w          element weight w[k] (signed)
//   s_mask       element sparsity bit (1 = use)
//   s_last       final beat of the frame
//   s_bias       frame bias, taken from beat 0 only
//   s_act_sel    frame activation select, taken from beat 0 only
//   m_valid      packed operation valid (neuron in_valid)
//   m_ready      neuron accepts (neuron in_ready)
//   m_x_flat     packed samples, element k at [k*X_W +: X_W]
//   m_w_flat     packed weights, element k at [k*W_W +: W_W]
//   m_mask_flat  packed mask, element k at bit k
//   m_bias       frame bias
//   m_act_sel    frame activation select
//   err_short    one-cycle pulse: frame ended early and was zero-padded
//   err_long     one-cycle pulse: frame overran, excess beats dropped
//   busy         high whenever the loader is not idle
// -----------------------------------------------------------------------------
module neuron_operand_loader #(
    parameter int NUM_INPUTS = 8,
    parameter int X_W        = 8,
    parameter int W_W        = 8,
    parameter int B_W        = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic signed [X_W-1:0]        s_x,
    input  logic signed [W_W-1:0]        s_w,
    input  logic                         s_mask,
    input  logic                         s_last,
    input  logic signed [B_W-1:0]        s_bias,
    input  logic [1:0]                   s_act_sel,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [NUM_INPUTS*X_W-1:0]    m_x_flat,
    output logic [NUM_INPUTS*W_W-1:0]    m_w_flat,
    output logic [NUM_INPUTS-1:0]        m_mask_flat,
    output logic signed [B_W-1:0]        m_bias,
    output logic [1:0]                   m_act_sel,
    output logic                         err_short,
    output logic                         err_long,
    output logic                         busy
);

    localparam int CNT_W = $clog2(NUM_INPUTS + 1);

    // Index of the final slot; reaching it decides between ISSUE and DRAIN.
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_INPUTS - 1);

    // A one-element frame is complete on its first beat, whatever s_last says.
    localparam bit SINGLE = (NUM_INPUTS == 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_ISSUE = 2'd3;

    logic [1:0]                   state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [NUM_INPUTS*X_W-1:0]    x_q, x_d;
    logic [NUM_INPUTS*W_W-1:0]    w_q, w_d;
    logic [NUM_INPUTS-1:0]        mask_q, mask_d;
    logic signed [B_W-1:0]        bias_q, bias_d;
    logic [1:0]                   act_q, act_d;
    logic                         err_short_q, err_short_d;
    logic                         err_long_q, err_long_d;
    logic                         beat_acc;

    // Input side is blocked only while a packed frame waits for the neuron.
    assign s_ready  = (state_q != S_ISSUE);
    assign beat_acc = s_valid && s_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        x_d         = x_q;
        w_d         = w_q;
        mask_d      = mask_q;
        bias_d      = bias_q;
        act_d       = act_q;
        err_short_d = 1'b0;
        err_long_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (beat_acc) begin
                    // Beat 0 clears every other slot so a short frame is
                    // already zero-padded without any extra work later.
                    x_d               = '0;
                    w_d               = '0;
                    mask_d            = '0;
                    x_d[X_W-1:0]      = s_x;
                    w_d[W_W-1:0]      = s_w;
                    mask_d[0]         = s_mask;
                    bias_d            = s_bias;
                    act_d             = s_act_sel;
                    cnt_d             = CNT_W'(1);
                    if (SINGLE || s_last) begin
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_FILL;
                    end
                    if (!SINGLE && s_last) begin
                        err_short_d = 1'b1;
                    end
                end
            end

            S_FILL: begin
                if (beat_acc) begin
                    for (int i = 1; i < NUM_INPUTS; i++) begin
                        if (cnt_q == CNT_W'(i)) begin
                            x_d[i*X_W +: X_W] = s_x;
                            w_d[i*W_W +: W_W] = s_w;
                            mask_d[i]         = s_mask;
                        end
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_IDX) begin
                        if (s_last) begin
                            state_d = S_ISSUE;
                        end else begin
                            // Frame is full but the source keeps going: keep
                            // the packed data and swallow the rest of it.
                            state_d    = S_DRAIN;
                            err_long_d = 1'b1;
                        end
                    end else if (s_last) begin
                        state_d     = S_ISSUE;
                        err_short_d = 1'b1;
                    end
                end
            end

            S_DRAIN: begin
                if (beat_acc && s_last) begin
                    state_d = S_ISSUE;
                end
            end

            S_ISSUE: begin
                if (m_ready) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Single register stage: control, packed data and error pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            x_q         <= '0;
            w_q         <= '0;
            mask_q      <= '0;
            bias_q      <= '0;
            act_q       <= '0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            x_q         <= x_d;
            w_q         <= w_d;
            mask_q      <= mask_d;
            bias_q      <= bias_d;
            act_q       <= act_d;
            err_short_q <= err_short_d;
            err_long_q  <= err_long_d;
        end
    end

    assign m_valid     = (state_q == S_ISSUE);
    assign m_x_flat    = x_q;
    assign m_w_flat    = w_q;
    assign m_mask_flat = mask_q;
    assign m_bias      = bias_q;
    assign m_act_sel   = act_q;
    assign err_short   = err_short_q;
    assign err_long    = err_long_q;
    assign busy        = (state_q != S_IDLE);

endmodule
